nvram_upload_server: RTL
========================

// Module: nvram_upload_server
// PURPOSE
//  Responder for the HPS ioctl upload path: the read-back counterpart of the ROM/DIP download path.
//  Serves HPS byte-read requests (ioctl_rd) for the NVRAM/hiscore region.
//  Freezes the game CPU through a pause handshake, reads the dual-port work RAM and returns
//  bytes on ioctl_din, throttling the HPS with ioctl_wait.
//  Sits in emu between hps_io and the game core's RAM B-port; runs on clk_sys.
// PARAMETERS
//  UPLOAD_INDEX  8'd4   ioctl_index value served; all other indices are ignored.
//  ADDR_W        10     RAM address width; the region is 2**ADDR_W bytes.
//  SAVE_SIZE     1024   bytes exposed; a read at ioctl_addr >= SAVE_SIZE returns 8'hFF.
//  RAM_LAT       1      cycles from ram_rd to valid ram_q (1..3).
// PORTS
//  clk_sys        in   1       system clock (9.987 MHz).
//  RESET_N        in   1       asynchronous active-low reset.
//  ioctl_upload   in   1       HPS upload session active.
//  ioctl_index    in   8       session index.
//  ioctl_rd       in   1       one-cycle byte read strobe.
//  ioctl_addr     in   25      byte address, valid with ioctl_rd.
//  ioctl_din      out  8       returned byte, held until the next fetch.
//  ioctl_wait     out  1       stall to HPS; high while data is not yet valid.
//  pause_req      out  1       request to the core to halt the CPU.
//  pause_ack      in   1       core confirms the CPU is halted (level).
//  ram_addr       out  ADDR_W  RAM B-port address.
//  ram_rd         out  1       RAM B-port read enable, one-cycle pulse.
//  ram_q          in   8       RAM B-port data.
//  busy           out  1       high in any state except IDLE.
// BEHAVIOUR
//  Reset values: all outputs 0; ioctl_din=8'h00; state IDLE.
//  sel = ioctl_upload & (ioctl_index==UPLOAD_INDEX).
//  FSM states: IDLE, HOLD, READY, FETCH, RELEASE.
//   IDLE -> HOLD when sel=1. pause_req goes high the next cycle.
//   HOLD: pause_req=1, wait for pause_ack=1, then -> READY.
//   READY: on ioctl_rd with ioctl_addr < SAVE_SIZE:
//     latch ram_addr = ioctl_addr[ADDR_W-1:0]; pulse ram_rd for 1 cycle; -> FETCH.
//   READY: on ioctl_rd with an out-of-range address:
//     ioctl_din <= 8'hFF next cycle; stay in READY; no RAM access.
//   FETCH: count RAM_LAT cycles, latch ram_q into ioctl_din, -> READY.
//     Latency from ioctl_rd to data = RAM_LAT+1 cycles.
//   In READY, HOLD or FETCH, sel falling -> RELEASE.
//     Any fetch in flight is abandoned; ioctl_din is not updated.
//   RELEASE: drop pause_req; -> IDLE when pause_ack=0.
//     A new sel seen in RELEASE is held off until IDLE.
//  ioctl_wait is combinational:
//     (state==HOLD) | (state==FETCH) | (state==READY & ioctl_rd & in-range).
//   It stays high from the rd cycle until the cycle ioctl_din is loaded.
//  ioctl_rd in HOLD or FETCH is a protocol error by HPS: ignored, no second fetch queued.
//  pause_ack dropping while in READY/FETCH: the FETCH in progress completes;
//     -> HOLD after it (a new rd waits).
//  ioctl_addr bits above ADDR_W are used only for the range check.
//  Async reset mid-session: returns to IDLE with pause_req=0 immediately.
//  busy = (state != IDLE).
// STRUCTURE
//  Shared package nvram_pkg: state enum (IDLE..RELEASE); UPLOAD_INDEX default; FILL_BYTE = 8'hFF.
//  One natural sub-module: nvram_lat_ctr.
//   Loadable down-counter for RAM_LAT with a done flag; reused by the download-side restorer.
//  Everything else is flat in this module. No dual-clock logic: all signals are on clk_sys.
// TESTING
//  1 Reset with sel=1: outputs 0 during reset; after release -> HOLD, pause_req=1, ioctl_wait=1.
//  2 pause_ack after 5 cycles; RAM[0x010]=0xA5, rd at addr 0x010 with RAM_LAT=1:
//    ioctl_wait high 2 cycles, ioctl_din=0xA5; ram_rd pulses exactly once.
//  3 rd at addr 0x500 (>= SAVE_SIZE 1024): ioctl_din=0xFF after 1 cycle, ram_rd stays 0.
//  4 Sequential reads of addr 0..1023 with back-to-back rd as ioctl_wait allows:
//    all bytes match the RAM image; pause_req stays high throughout.
//  5 ioctl_upload drops during FETCH: -> RELEASE; ioctl_din unchanged;
//    pause_req drops next cycle; state is IDLE after pause_ack=0.
//  6 Wrong ioctl_index (0) with upload=1: no pause_req, busy=0, ioctl_wait=0 for 100 cycles.

Source files
------------

// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload/download helpers.
// State encoding and fill byte for out-of-range reads.
package nvram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_READY,
        ST_FETCH,
        ST_RELEASE
    } state_e;

    localparam logic [7:0] UPLOAD_INDEX_DEF = 8'd4;
    localparam logic [7:0] FILL_BYTE        = 8'hFF;

endpackage

// File: rtl/nvram_upload_server_if.sv
// HPS ioctl upload-side bundle.
// master = hps_io side, slave = the upload responder.
interface nvram_upload_server_if;

    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait
    );

endinterface

// File: rtl/nvram_lat_ctr.sv
// Loadable down-counter for RAM read latency.
// done is high on the last cycle of the loaded count.
module nvram_lat_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/nvram_upload_server.sv
// HPS upload responder: pauses the core CPU and serves NVRAM bytes
// from the work RAM B-port back to hps_io.
module nvram_upload_server
    import nvram_pkg::*;
#(
    parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEF,
    parameter int         ADDR_W       = 10,
    parameter int         SAVE_SIZE    = 1024,
    parameter int         RAM_LAT      = 1
) (
    input  logic                  clk_sys,
    input  logic                  RESET_N,
    nvram_upload_server_if.slave  ioctl,
    output logic                  pause_req,
    input  logic                  pause_ack,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_rd,
    input  logic [7:0]            ram_q,
    output logic                  busy
);

    localparam int LW = 2;

    state_e              state_q, state_d;
    logic [7:0]          din_q, din_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                pause_req_q, pause_req_d;
    logic                sel;
    logic                in_range;
    logic                rd_ok;
    logic                issue;
    logic                lat_done;

    assign sel      = ioctl.ioctl_upload
                    & (ioctl.ioctl_index == UPLOAD_INDEX);
    assign in_range = ioctl.ioctl_addr < 25'(SAVE_SIZE);
    assign rd_ok    = ioctl.ioctl_rd & in_range;
    assign issue    = (state_q == ST_READY) & sel
                    & pause_ack & rd_ok;

    nvram_lat_ctr #(
        .W (LW)
    ) u_lat_ctr (
        .clk      (clk_sys),
        .rst_n    (RESET_N),
        .load     (issue),
        .load_val (LW'(RAM_LAT)),
        .done     (lat_done)
    );

    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        ram_addr_d = ram_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!sel)          state_d = ST_RELEASE;
                else if (pause_ack) state_d = ST_READY;
            end
            ST_READY: begin
                if (!sel) begin
                    state_d = ST_RELEASE;
                end else if (!pause_ack) begin
                    state_d = ST_HOLD;
                end else if (ioctl.ioctl_rd) begin
                    if (in_range) begin
                        state_d    = ST_FETCH;
                        ram_addr_d = ioctl.ioctl_addr[ADDR_W-1:0];
                    end else begin
                        din_d = FILL_BYTE;
                    end
                end
            end
            // Abandoning on sel loss wins over a completing fetch.
            ST_FETCH: begin
                if (!sel) begin
                    state_d = ST_RELEASE;
                end else if (lat_done) begin
                    din_d   = ram_q;
                    state_d = pause_ack ? ST_READY : ST_HOLD;
                end
            end
            ST_RELEASE: begin
                if (!pause_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pause_req_d = (state_d == ST_HOLD)
                    | (state_d == ST_READY)
                    | (state_d == ST_FETCH);
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            din_q       <= 8'h00;
            ram_addr_q  <= '0;
            pause_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            ram_addr_q  <= ram_addr_d;
            pause_req_q <= pause_req_d;
        end
    end

    // Address goes out in the rd cycle so RAM_LAT counts from there.
    assign ram_addr = issue ? ioctl.ioctl_addr[ADDR_W-1:0]
                            : ram_addr_q;
    assign ram_rd   = issue;

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = (state_q == ST_HOLD)
                            | (state_q == ST_FETCH)
                            | ((state_q == ST_READY) & rd_ok);

    assign pause_req = pause_req_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
